// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the TSC multi-cycle control unit: states, ISA opcodes/funcs,
// datapath mux selectors and the instruction-class one-hot.
package mc_control_unit_pkg;

  localparam int OP_W = 4;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [OP_W-1:0] OP_BNE = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ = 4'd1;
  localparam logic [OP_W-1:0] OP_BGZ = 4'd2;
  localparam logic [OP_W-1:0] OP_BLZ = 4'd3;
  localparam logic [OP_W-1:0] OP_ADI = 4'd4;
  localparam logic [OP_W-1:0] OP_ORI = 4'd5;
  localparam logic [OP_W-1:0] OP_LHI = 4'd6;
  localparam logic [OP_W-1:0] OP_LWD = 4'd7;
  localparam logic [OP_W-1:0] OP_SWD = 4'd8;
  localparam logic [OP_W-1:0] OP_JMP = 4'd9;
  localparam logic [OP_W-1:0] OP_JAL = 4'd10;
  localparam logic [OP_W-1:0] OP_ALU = 4'd15;

  // ADD..SHR occupy func 0..7; FN_SHR bounds the R-type range
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_R2 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  typedef struct packed {
    logic rtype;
    logic imm;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic jal;
    logic jpr;
    logic jrl;
    logic wwd;
    logic hlt;
  } iclass_t;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational opcode/func decode into an instruction-class one-hot.
// An all-zero class marks an undefined encoding.
module mc_instr_class
  import mc_control_unit_pkg::*;
#(
  parameter int FUNC_W = 6
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func_code,
  output iclass_t           cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.branch = 1'b1;
      OP_ADI, OP_ORI, OP_LHI:         cls.imm    = 1'b1;
      OP_LWD:                         cls.load   = 1'b1;
      OP_SWD:                         cls.store  = 1'b1;
      OP_JMP:                         cls.jump   = 1'b1;
      OP_JAL:                         cls.jal    = 1'b1;
      OP_ALU: begin
        if (func_code <= FUNC_W'(FN_SHR)) cls.rtype = 1'b1;
        else if (func_code == FUNC_W'(FN_JPR)) cls.jpr = 1'b1;
        else if (func_code == FUNC_W'(FN_JRL)) cls.jrl = 1'b1;
        else if (func_code == FUNC_W'(FN_WWD)) cls.wwd = 1'b1;
        else if (func_code == FUNC_W'(FN_HLT)) cls.hlt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 16-bit TSC datapath.
// state | meaning
// S_IF   | fetch over shared memory port, hold until mem_ready, then PC <- PC+1
// S_ID   | decode, ALUOut <- PC+imm; JMP/JAL/WWD/NOP retire here
// S_EX   | ALU operation, branch resolve, JPR/JRL retire here
// S_MEM  | LWD/SWD data access, hold until mem_ready
// S_WB   | register file write-back
// S_HALT | HLT reached, only reset leaves
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int FUNC_W    = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-13:0] opcode,
  input  logic [FUNC_W-1:0]    func_code,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 alu_force_add,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 output_active,
  output logic                 is_halted,
  output logic                 inst_done
);

  state_t  state;
  logic    active;
  iclass_t cls;
  logic    nop;
  logic    zext;
  logic    unused_bcond;

  // bcond gates the PC load in the datapath through pc_write_cond; sequencing ignores it
  assign unused_bcond = bcond;

  mc_instr_class #(.FUNC_W(FUNC_W)) u_instr_class (
    .opcode    (opcode),
    .func_code (func_code),
    .cls       (cls)
  );

  assign nop  = ~|cls;
  assign zext = (opcode == OP_ORI) || (opcode == OP_LHI);

  // active holds every output low for the first cycle after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IF;
      active <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      case (state)
        S_IF: if (mem_ready) state <= S_ID;
        S_ID: begin
          if (cls.hlt) state <= S_HALT;
          else if (cls.jump || cls.jal || cls.wwd || nop) state <= S_IF;
          else state <= S_EX;
        end
        S_EX: begin
          if (cls.load || cls.store) state <= S_MEM;
          else if (cls.rtype || cls.imm) state <= S_WB;
          else state <= S_IF;
        end
        S_MEM:  if (mem_ready) state <= cls.load ? S_WB : S_IF;
        S_WB:   state <= S_IF;
        S_HALT: state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // The IR is only valid once IF completes, so outputs decode the live IR rather than being pre-registered
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCS_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_force_add = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALU;
    output_active = 1'b0;
    is_halted     = 1'b0;
    inst_done     = 1'b0;
    if (active) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write      = 1'b1;
            pc_write      = 1'b1;
            pc_source     = PCS_ALU;
            alu_src_b     = SRCB_ONE;
            alu_force_add = 1'b1;
          end
        end
        S_ID: begin
          alu_src_b     = SRCB_SEXT;
          alu_force_add = 1'b1;
          if (cls.jump || cls.jal) begin
            pc_write  = 1'b1;
            pc_source = PCS_JUMP;
            inst_done = 1'b1;
          end
          if (cls.jal) begin
            reg_write  = 1'b1;
            reg_dst    = DST_R2;
            mem_to_reg = M2R_PC;
          end
          if (cls.wwd) begin
            output_active = 1'b1;
            inst_done     = 1'b1;
          end
          if (nop) inst_done = 1'b1;
        end
        S_EX: begin
          if (cls.rtype) begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_RT;
          end
          if (cls.imm || cls.load || cls.store) begin
            alu_src_a = 1'b1;
            alu_src_b = zext ? SRCB_ZEXT : SRCB_SEXT;
          end
          if (cls.branch) begin
            alu_src_a     = 1'b1;
            alu_src_b     = SRCB_RT;
            pc_write_cond = 1'b1;
            pc_source     = PCS_ALUOUT;
            inst_done     = 1'b1;
          end
          if (cls.jpr || cls.jrl) begin
            pc_write  = 1'b1;
            pc_source = PCS_RS;
            inst_done = 1'b1;
          end
          if (cls.jrl) begin
            reg_write  = 1'b1;
            reg_dst    = DST_R2;
            mem_to_reg = M2R_PC;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = cls.load;
          mem_write = cls.store;
          inst_done = cls.store && mem_ready;
        end
        S_WB: begin
          reg_write  = 1'b1;
          inst_done  = 1'b1;
          reg_dst    = cls.rtype ? DST_RD : DST_RT;
          mem_to_reg = cls.load ? M2R_MDR : M2R_ALU;
        end
        S_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model expands each
// instruction into its expected per-cycle control trace, compared with the DUT.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] opcode;
  logic [5:0] func_code;
  logic       bcond;
  logic       mem_ready;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_force_add, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       output_active, is_halted, inst_done;

  mc_control_unit dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
    .bcond(bcond), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_force_add(alu_force_add), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .output_active(output_active), .is_halted(is_halted),
    .inst_done(inst_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_force_add, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       output_active, is_halted, inst_done;
  } ctl_t;

  typedef struct {
    ctl_t       exp;
    ctl_t       care;
    bit         rdy;
    bit         ir;
    logic [3:0] op;
    logic [5:0] fn;
  } ent_t;

  typedef enum {K_R, K_IMM, K_LD, K_ST, K_BR, K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_t;

  ent_t trace_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   obs_done = 0;
  int   bc_force = -1;

  function automatic ctl_t observed();
    return {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
            alu_src_a, alu_src_b, alu_force_add, reg_write, reg_dst, mem_to_reg,
            output_active, is_halted, inst_done};
  endfunction

  function automatic kind_t kind_of(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd3) return K_BR;
    if (op >= 4'd4 && op <= 4'd6) return K_IMM;
    if (op == 4'd7) return K_LD;
    if (op == 4'd8) return K_ST;
    if (op == 4'd9) return K_JMP;
    if (op == 4'd10) return K_JAL;
    if (op == 4'd15) begin
      if (fn <= 6'd7) return K_R;
      if (fn == 6'd25) return K_JPR;
      if (fn == 6'd26) return K_JRL;
      if (fn == 6'd28) return K_WWD;
      if (fn == 6'd29) return K_HLT;
    end
    return K_NOP;
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input ctl_t e, input ctl_t c, input bit rdy, input bit ir,
                      input logic [3:0] op, input logic [5:0] fn);
    ent_t t;
    t.exp = e; t.care = c; t.rdy = rdy; t.ir = ir; t.op = op; t.fn = fn;
    trace_q.push_back(t);
  endtask

  // Expand one instruction into its expected cycle trace (w_if/w_mem = memory wait cycles)
  task automatic model_instr(input logic [3:0] op, input logic [5:0] fn,
                             input int w_if, input int w_mem);
    kind_t k;
    ctl_t  e, c;
    k = kind_of(op, fn);
    for (int i = 0; i < w_if; i++) begin
      e = '0; e.mem_read = 1'b1;
      c = '1; c.pc_source = '0; c.alu_src_a = 1'b0; c.alu_src_b = '0; c.alu_force_add = 1'b0;
      push(e, c, 1'b0, 1'b0, op, fn);
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    e.alu_src_b = 2'd1; e.alu_force_add = 1'b1;
    push(e, '1, 1'b1, 1'b0, op, fn);

    e = '0; e.alu_src_b = 2'd2; e.alu_force_add = 1'b1;
    if (k == K_JMP || k == K_JAL) begin
      e.pc_write = 1'b1; e.pc_source = 2'd2; e.inst_done = 1'b1;
      if (k == K_JAL) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
    end
    if (k == K_WWD) begin e.output_active = 1'b1; e.inst_done = 1'b1; end
    if (k == K_NOP) e.inst_done = 1'b1;
    push(e, '1, rnd_bit(), 1'b1, op, fn);
    if (k inside {K_JMP, K_JAL, K_WWD, K_NOP, K_HLT}) return;

    e = '0; c = '1;
    case (k)
      K_R:  e.alu_src_a = 1'b1;
      K_IMM, K_LD, K_ST: begin
        c.alu_src_a = 1'b0;
        e.alu_src_b = (op == 4'd5 || op == 4'd6) ? 2'd3 : 2'd2;
      end
      K_BR: begin
        e.alu_src_a = 1'b1; e.pc_write_cond = 1'b1; e.pc_source = 2'd1; e.inst_done = 1'b1;
      end
      default: begin
        c.alu_src_a = 1'b0; c.alu_src_b = '0;
        e.pc_write = 1'b1; e.pc_source = 2'd3; e.inst_done = 1'b1;
        if (k == K_JRL) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
      end
    endcase
    push(e, c, rnd_bit(), 1'b1, op, fn);
    if (k inside {K_BR, K_JPR, K_JRL}) return;

    if (k == K_LD || k == K_ST) begin
      e = '0; e.i_or_d = 1'b1; e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
      for (int i = 0; i < w_mem; i++) push(e, '1, 1'b0, 1'b1, op, fn);
      e.inst_done = (k == K_ST);
      push(e, '1, 1'b1, 1'b1, op, fn);
      if (k == K_ST) return;
    end

    e = '0; e.reg_write = 1'b1; e.inst_done = 1'b1;
    e.reg_dst = (k == K_R) ? 2'd1 : 2'd0;
    e.mem_to_reg = (k == K_LD) ? 2'd1 : 2'd0;
    push(e, '1, rnd_bit(), 1'b1, op, fn);
  endtask

  task automatic run_trace(input string name, input int max_cyc);
    int          n;
    ent_t        t;
    logic [19:0] got, exp, care;
    n = 0;
    while (trace_q.size() > 0 && (max_cyc < 0 || n < max_cyc)) begin
      t = trace_q.pop_front();
      @(negedge clk);
      mem_ready = t.rdy;
      bcond = (bc_force < 0) ? rnd_bit() : bc_force[0];
      if (t.ir) begin opcode = t.op; func_code = t.fn; end
      else begin opcode = 4'($urandom); func_code = 6'($urandom); end
      #1;
      got = observed(); exp = t.exp; care = t.care;
      if (got[0] === 1'b1) obs_done++;
      n_checks++;
      if ((got & care) !== (exp & care))
        $display("FAIL %s cycle %0d: outputs %05h, required %05h (care %05h)", name, n, got, exp, care);
      else n_pass++;
      n++;
    end
    trace_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; opcode = 4'd7; func_code = 6'd0; bcond = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (observed() !== ctl_t'('0)) $display("FAIL reset_idle: outputs %05h, required 00000", observed());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({mem_read, i_or_d} !== 2'b10)
      $display("FAIL fetch_after_reset: mem_read,i_or_d %b, required 10", {mem_read, i_or_d});
    else n_pass++;
  endtask

  task automatic test_add();
    obs_done = 0;
    model_instr(4'd15, 6'd0, 0, 0);
    run_trace("add", -1);
    n_checks++;
    if (obs_done !== 1) $display("FAIL add_done_pulses: got %0d, required 1", obs_done);
    else n_pass++;
  endtask

  task automatic test_lwd_wait();
    model_instr(4'd7, 6'($urandom), 0, 3);
    n_checks++;
    if (trace_q.size() !== 8) $display("FAIL lwd_cycle_count: model %0d, required 8", trace_q.size());
    else n_pass++;
    run_trace("lwd_wait", -1);
  endtask

  task automatic test_branch();
    bc_force = 1;
    model_instr(4'd1, 6'($urandom), 0, 0);
    run_trace("beq_taken", -1);
    bc_force = 0;
    model_instr(4'd1, 6'($urandom), 0, 0);
    run_trace("beq_not_taken", -1);
    bc_force = -1;
  endtask

  task automatic test_jal();
    model_instr(4'd10, 6'($urandom), 0, 0);
    model_instr(4'd15, 6'd1, 1, 0);
    run_trace("jal", -1);
  endtask

  task automatic test_reset_mid_mem();
    model_instr(4'd7, 6'd0, 0, 5);
    run_trace("lwd_pre_abort", 5);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({mem_read, i_or_d} !== 2'b11)
      $display("FAIL mem_hold: mem_read,i_or_d %b, required 11", {mem_read, i_or_d});
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== ctl_t'('0)) $display("FAIL abort_mid_mem: outputs %05h, required 00000", observed());
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({mem_read, i_or_d} !== 2'b10)
      $display("FAIL refetch_after_abort: mem_read,i_or_d %b, required 10", {mem_read, i_or_d});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [5:0] fn;
    obs_done = 0;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      fn = rnd_bit() ? 6'($urandom_range(0, 7)) : 6'($urandom_range(8, 63));
      if (op == 4'd15 && fn == 6'd29) fn = 6'd2;
      model_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_trace("random", -1);
    n_checks++;
    if (obs_done !== 40) $display("FAIL random_retired: got %0d, required 40", obs_done);
    else n_pass++;
  endtask

  task automatic test_wwd_hlt();
    ctl_t e;
    model_instr(4'd15, 6'd28, 0, 0);
    model_instr(4'd15, 6'd29, 1, 0);
    e = '0; e.is_halted = 1'b1;
    for (int i = 0; i < 20; i++) push(e, '1, rnd_bit(), 1'b1, 4'd15, 6'd29);
    run_trace("wwd_hlt", -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lwd_wait();
    test_branch();
    test_jal();
    test_reset_mid_mem();
    test_back_to_back();
    test_wwd_hlt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
